// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - sequential switch/button ALU with debounced loads and shift-add multiply
// Buttons are synchronised and debounced into single pulses that drive a four-state FSM.
module alu_seq_core #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             btn_op,
  input  logic             btn_exec,
  input  logic             acc_mode,
  input  logic             sel_hi,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX  = CW'(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam int MW = $clog2(WIDTH);
  localparam logic [MW-1:0] MUL_LAST = MW'(WIDTH - 1);
  localparam int M = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  logic [3:0]    w_raw;
  logic [3:0]    r_sync1, r_sync2, r_pulse;
  logic [CW-1:0] r_cnt [4];

  assign w_raw = {btn_exec, btn_op, btn_b, btn_a};

  // Pulse is registered on the edge where the counter reaches DB_MAX, so a held button fires once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_pulse <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_pulse[i] <= r_sync2[i] && (r_cnt[i] == DB_LAST);
        if (!r_sync2[i])
          r_cnt[i] <= '0;
        else if (r_cnt[i] != DB_MAX)
          r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  logic w_pa, w_pb, w_po, w_pe;
  assign w_pa = r_pulse[0];
  assign w_pb = r_pulse[1];
  assign w_po = r_pulse[2];
  assign w_pe = r_pulse[3];

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_hi;
  logic [3:0]       r_op;
  logic             r_z, r_c, r_n, r_v;
  logic             r_busy, r_done, r_last_mul, r_acc_ok;
  logic [2*WIDTH-1:0] r_prod;
  logic [MW-1:0]    r_mcnt;

  logic [3:0]       w_op_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  assign w_op_nxt = w_po ? sw[3:0] : r_op;
  assign w_b_nxt  = w_pb ? sw : r_b;

  logic [WIDTH:0] w_add, w_sub;
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};

  logic [WIDTH-1:0] w_res;
  logic w_c, w_v, w_wr, w_acc, w_clr_flags, w_z, w_n;

  always_comb begin
    w_res       = r_b;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_wr        = 1'b1;
    w_acc       = 1'b1;
    w_clr_flags = 1'b0;
    case (r_op)
      4'd0: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_a[M] == r_b[M]) && (w_add[M] != r_a[M]);
      end
      4'd1, 4'd9: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_a[M] != r_b[M]) && (w_sub[M] != r_a[M]);
        if (r_op == 4'd9) begin
          w_wr  = 1'b0;
          w_acc = 1'b0;
        end
      end
      4'd2: w_res = r_a & r_b;
      4'd3: w_res = r_a | r_b;
      4'd4: w_res = r_a ^ r_b;
      4'd5: w_res = ~r_a;
      4'd6: begin
        w_res = {r_a[WIDTH-2:0], 1'b0};
        w_c   = r_a[M];
      end
      4'd7: begin
        w_res = {1'b0, r_a[WIDTH-1:1]};
        w_c   = r_a[0];
      end
      default: begin
        w_acc       = 1'b0;
        w_clr_flags = 1'b1;
      end
    endcase
    w_z = (w_res == '0) && !w_clr_flags;
    w_n = w_res[M] && !w_clr_flags;
  end

  // Shift-add: add A into the high half when the multiplier LSB (held in the low half) is set.
  logic [WIDTH:0]       w_msum;
  logic [2*WIDTH-1:0]   w_prod_nxt;
  assign w_msum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_msum, r_prod[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_res      <= '0;
      r_hi       <= '0;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_n        <= 1'b0;
      r_v        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_last_mul <= 1'b0;
      r_acc_ok   <= 1'b0;
      r_prod     <= '0;
      r_mcnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pa) r_a <= sw;
          if (w_pb) r_b <= sw;
          if (w_po) r_op <= sw[3:0];
          if (w_pe) begin
            r_busy <= 1'b1;
            if (w_op_nxt == 4'd8) begin
              r_prod  <= {{WIDTH{1'b0}}, w_b_nxt};
              r_mcnt  <= '0;
              r_state <= S_MUL;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (w_wr) r_res <= w_res;
          r_z        <= w_z;
          r_c        <= w_c;
          r_n        <= w_n;
          r_v        <= w_v;
          r_last_mul <= 1'b0;
          r_acc_ok   <= w_acc;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_MUL: begin
          r_prod <= w_prod_nxt;
          r_mcnt <= r_mcnt + MW'(1);
          if (r_mcnt == MUL_LAST) begin
            r_res      <= w_prod_nxt[WIDTH-1:0];
            r_hi       <= w_prod_nxt[2*WIDTH-1:WIDTH];
            r_z        <= (w_prod_nxt[WIDTH-1:0] == '0);
            r_n        <= w_prod_nxt[M];
            r_c        <= |w_prod_nxt[2*WIDTH-1:WIDTH];
            r_v        <= 1'b0;
            r_last_mul <= 1'b1;
            r_acc_ok   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (acc_mode && r_acc_ok) r_a <= r_res;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = (sel_hi && r_last_mul) ? r_hi : r_res;
  assign flag_z = r_z;
  assign flag_c = r_c;
  assign flag_n = r_n;
  assign flag_v = r_v;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - directed self-checking bench for alu_seq_core
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_seq_core;

  localparam int W  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0, btn_exec = 1'b0;
  logic         acc_mode = 1'b0, sel_hi = 1'b0;
  logic [W-1:0] result;
  logic         flag_z, flag_c, flag_n, flag_v, busy, done;

  int checks = 0;
  int errors = 0;

  alu_seq_core #(.WIDTH(W), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_a(btn_a), .btn_b(btn_b), .btn_op(btn_op), .btn_exec(btn_exec),
    .acc_mode(acc_mode), .sel_hi(sel_hi),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = A, 1 = B, 2 = opcode
  task automatic press(input int which, input logic [W-1:0] v, input int hold);
    @(negedge clk);
    sw = v;
    if (which == 0) btn_a = 1'b1;
    else if (which == 1) btn_b = 1'b1;
    else btn_op = 1'b1;
    repeat (hold) @(negedge clk);
    btn_a  = 1'b0;
    btn_b  = 1'b0;
    btn_op = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic load3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] op);
    press(0, a, 10);
    press(1, b, 10);
    press(2, op, 10);
  endtask

  // Latency counted in rising edges from the first edge that samples btn_exec high.
  task automatic do_exec(input string tag, input int exp_lat, input int exp_busy, input bit poke);
    int lat;
    int bcnt;
    bit seen;
    lat  = 0;
    bcnt = 0;
    seen = 1'b0;
    @(negedge clk);
    btn_exec = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (poke && i == 8) begin
        sw    = 8'h11;
        btn_b = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
    check({tag, "_done_seen"}, 16'(seen), 16'd1);
    check({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    check({tag, "_busy_cycles"}, 16'(bcnt), 16'(exp_busy));
    btn_exec = 1'b0;
    btn_b    = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  int dcnt;

  initial begin
    #1;
    check("reset_result", 16'(result), 16'h00);
    check("reset_flags", 16'({flag_z, flag_c, flag_n, flag_v}), 16'h0);
    check("reset_busy_done", 16'({busy, done}), 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Glitch on btn_a shorter than the debounce window must not load A.
    press(1, 8'h00, 10);
    press(2, 8'h03, 10);
    @(negedge clk);
    sw    = 8'h5A;
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    btn_a = 1'b0;
    repeat (6) @(negedge clk);
    do_exec("glitch", 8, 1, 1'b0);
    check("glitch_a_unchanged", 16'(result), 16'h00);
    check("glitch_z", 16'(flag_z), 16'h1);
    press(0, 8'h5A, 10);
    do_exec("hold", 8, 1, 1'b0);
    check("hold_a_loaded", 16'(result), 16'h5A);

    // ADD with signed overflow
    load3(8'h7F, 8'h01, 8'h00);
    do_exec("add", 8, 1, 1'b0);
    check("add_result", 16'(result), 16'h80);
    check("add_flags_zcnv", 16'({flag_z, flag_c, flag_n, flag_v}), 16'b0010 | 16'b0001);

    // CMP equal leaves result untouched
    load3(8'h10, 8'h10, 8'h09);
    do_exec("cmp", 8, 1, 1'b0);
    check("cmp_result_kept", 16'(result), 16'h80);
    check("cmp_flags_zcnv", 16'({flag_z, flag_c, flag_n, flag_v}), 16'b1000);

    // SUB with borrow
    press(1, 8'h20, 10);
    press(2, 8'h01, 10);
    do_exec("sub", 8, 1, 1'b0);
    check("sub_result", 16'(result), 16'hF0);
    check("sub_flags_zcnv", 16'({flag_z, flag_c, flag_n, flag_v}), 16'b0110);

    // SHL carries out the MSB
    load3(8'h81, 8'h00, 8'h06);
    do_exec("shl", 8, 1, 1'b0);
    check("shl_result", 16'(result), 16'h02);
    check("shl_flags_zcnv", 16'({flag_z, flag_c, flag_n, flag_v}), 16'b0100);

    // Reserved opcode passes B with all flags clear, even when B is zero
    press(2, 8'h0C, 10);
    do_exec("rsvd", 8, 1, 1'b0);
    check("rsvd_result", 16'(result), 16'h00);
    check("rsvd_flags_zcnv", 16'({flag_z, flag_c, flag_n, flag_v}), 16'b0000);

    // MUL 0xFF*0xFF = 0xFE01; a B load arriving mid-multiply must be dropped
    load3(8'hFF, 8'hFF, 8'h08);
    do_exec("mul", 15, 8, 1'b1);
    check("mul_low", 16'(result), 16'h01);
    check("mul_flags_zcnv", 16'({flag_z, flag_c, flag_n, flag_v}), 16'b0100);
    sel_hi = 1'b1;
    #1;
    check("mul_high", 16'(result), 16'hFE);
    sel_hi = 1'b0;
    do_exec("mul2", 15, 8, 1'b0);
    check("mul2_low_b_unchanged", 16'(result), 16'h01);
    sel_hi = 1'b1;
    #1;
    check("mul2_high_b_unchanged", 16'(result), 16'hFE);
    sel_hi = 1'b0;

    // Accumulate chains results back into A
    acc_mode = 1'b1;
    load3(8'h01, 8'h01, 8'h00);
    do_exec("acc1", 8, 1, 1'b0);
    check("acc1_result", 16'(result), 16'h02);
    do_exec("acc2", 8, 1, 1'b0);
    check("acc2_result", 16'(result), 16'h03);
    do_exec("acc3", 8, 1, 1'b0);
    check("acc3_result", 16'(result), 16'h04);
    acc_mode = 1'b0;

    // Async reset in the middle of a multiply
    load3(8'h03, 8'h05, 8'h08);
    @(negedge clk);
    btn_exec = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_mul_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_result", 16'(result), 16'h00);
    check("rst_mid_flags", 16'({flag_z, flag_c, flag_n, flag_v}), 16'h0);
    check("rst_mid_busy_done", 16'({busy, done}), 16'h0);
    btn_exec = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (i == 4) rst = 1'b0;
    end
    check("rst_no_done", 16'(dcnt), 16'h0);
    load3(8'h03, 8'h05, 8'h08);
    do_exec("post_rst_mul", 15, 8, 1'b0);
    check("post_rst_mul_low", 16'(result), 16'h0F);
    check("post_rst_mul_flags", 16'({flag_z, flag_c, flag_n, flag_v}), 16'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
